// File: rtl/shift_reg_seq_if.sv
// shift_reg_seq_if -- request/response bundle for the sequential shift register.
//   start    : operation request, sampled only while the block is idle
//   op       : operation code, sampled with start
//   amount   : number of single-bit steps, sampled with start
//   data_in  : parallel load value
//   i_right  : serial fill bit entering the LSB on shift-left
//   i_left   : serial fill bit entering the MSB on shift-right
//   data_out : register contents
//   busy     : high whenever the block is not idle
//   done     : one-cycle completion pulse
// The master modport drives requests; the slave modport is the shift register.
interface shift_reg_seq_if #(
  parameter int N  = 8,
  parameter int AW = $clog2(N) + 1
);
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] amount;
  logic [N-1:0]  data_in;
  logic          i_right;
  logic          i_left;
  logic [N-1:0]  data_out;
  logic          busy;
  logic          done;

  modport master (
    output start, op, amount, data_in, i_right, i_left,
    input  data_out, busy, done
  );

  modport slave (
    input  start, op, amount, data_in, i_right, i_left,
    output data_out, busy, done
  );
endinterface

// File: rtl/shift_reg_seq.sv
// shift_reg_seq -- N-bit register with load, shift, rotate and arithmetic
// shift operations executed one bit per clock under a three-state sequencer.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears data and sequencer)
//   bus   : slave side of shift_reg_seq_if (request, serial fills, result)
// Op codes: 0 nop, 1 load, 2 shl, 3 shr (i_left fill), 4 rol, 5 ror,
// 6 asr, 7 reserved (nop).
module shift_reg_seq #(
  parameter int N  = 8,
  parameter int AW = $clog2(N) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_reg_seq_if.slave       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  data_q,  data_d;
  logic [AW-1:0] rem_q,   rem_d;
  logic [2:0]    op_q,    op_d;

  // One single-bit step of a shift/rotate op; serial fills come straight
  // from the ports so they are sampled on every step edge.
  function automatic logic [N-1:0] step(input logic [2:0]   o,
                                        input logic [N-1:0] v,
                                        input logic         ir,
                                        input logic         il);
    logic [N-1:0] r;
    r = v;
    case (o)
      3'd2:    r = {v[N-2:0], ir};
      3'd3:    r = {il, v[N-1:1]};
      3'd4:    r = {v[N-2:0], v[N-1]};
      3'd5:    r = {v[0], v[N-1:1]};
      3'd6:    r = {v[N-1], v[N-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            3'd1: begin
              data_d  = bus.data_in;
              state_d = DONE;
            end
            3'd2, 3'd3, 3'd4, 3'd5, 3'd6: begin
              if (bus.amount == '0) begin
                state_d = DONE;
              end else begin
                op_d    = bus.op;
                // Anything beyond N steps saturates at N.
                rem_d   = (bus.amount > AW'(N)) ? AW'(N) : bus.amount;
                state_d = RUN;
              end
            end
            default: state_d = DONE;
          endcase
        end
      end
      RUN: begin
        data_d = step(op_q, data_q, bus.i_right, bus.i_left);
        rem_d  = rem_q - AW'(1);
        if (rem_q == AW'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status is decoded purely from the state flops.
  assign bus.data_out = data_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_shift_reg_seq.sv
// tb_shift_reg_seq -- directed and randomized checks of shift_reg_seq (N=8)
// against an arithmetic reference model of each single-bit step.
module tb_shift_reg_seq;
  localparam int N  = 8;
  localparam int AW = $clog2(N) + 1;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  logic [7:0] cur;

  shift_reg_seq_if #(.N(N), .AW(AW)) bus ();

  shift_reg_seq #(.N(N), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference step, written as plain arithmetic on the unsigned value.
  function automatic logic [7:0] step_model(input logic [2:0] o, input logic [7:0] v,
                                            input logic ir, input logic il);
    int x;
    int r;
    x = int'(v);
    case (o)
      3'd2:    r = (x * 2 + int'(ir)) % 256;
      3'd3:    r = x / 2 + int'(il) * 128;
      3'd4:    r = (x * 2) % 256 + x / 128;
      3'd5:    r = x / 2 + (x % 2) * 128;
      3'd6:    r = x / 2 + (x / 128) * 128;
      default: r = x;
    endcase
    return r[7:0];
  endfunction

  // Issue one request and follow it to its done pulse. ir_sel/il_sel:
  // 0 or 1 forces that fill value, 2 randomizes it every cycle.
  // poke pulses start with a load during the first RUN cycle.
  task automatic do_op(input string tag, input logic [2:0] o, input int amt,
                       input logic [7:0] din, input int ir_sel, input int il_sel,
                       input bit poke);
    int steps;
    int lat;
    int cyc;
    logic ir;
    logic il;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = o;
    bus.amount  = amt[AW-1:0];
    bus.data_in = din;
    if (o == 3'd1) begin
      cur   = din;
      steps = 0;
    end else if (o >= 3'd2 && o <= 3'd6 && amt > 0) begin
      steps = (amt > N) ? N : amt;
    end else begin
      steps = 0;
    end
    lat = steps + 1;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.op      = 3'($urandom);
    bus.amount  = AW'($urandom);
    bus.data_in = 8'($urandom);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc <= N + 3) begin
      chk({tag, "_busy_run"}, 64'(bus.busy), 64'd1);
      if (poke && cyc == 1) begin
        bus.start   = 1'b1;
        bus.op      = 3'd1;
        bus.data_in = ~cur;
      end else begin
        bus.start = 1'b0;
      end
      ir = (ir_sel == 2) ? 1'($urandom) : 1'(ir_sel);
      il = (il_sel == 2) ? 1'($urandom) : 1'(il_sel);
      bus.i_right = ir;
      bus.i_left  = il;
      if (steps > 0) begin
        cur = step_model(o, cur, ir, il);
        steps--;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    chk({tag, "_done"}, 64'(bus.done), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    chk({tag, "_data"}, 64'(bus.data_out), 64'(cur));
    chk({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
    @(negedge clk);
    chk({tag, "_done_clr"}, 64'(bus.done), 64'd0);
    chk({tag, "_busy_clr"}, 64'(bus.busy), 64'd0);
    chk({tag, "_data_hold"}, 64'(bus.data_out), 64'(cur));
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    cur         = 8'h00;
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.op      = 3'd0;
    bus.amount  = '0;
    bus.data_in = 8'h00;
    bus.i_right = 1'b0;
    bus.i_left  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_data", 64'(bus.data_out), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;

    // Idle with start low holds everything
    bus.data_in = 8'h3C;
    repeat (3) @(negedge clk);
    chk("idle_hold", 64'(bus.data_out), 64'd0);
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // Directed vectors
    do_op("load64", 3'd1, 0, 8'h64, 0, 0, 1'b0);
    chk("load64_const", 64'(bus.data_out), 64'h64);
    do_op("shl1", 3'd2, 1, 8'h00, 1, 0, 1'b0);
    chk("shl1_const", 64'(bus.data_out), 64'hC9);
    do_op("shr1", 3'd3, 1, 8'h00, 0, 1, 1'b0);
    chk("shr1_const", 64'(bus.data_out), 64'hE4);
    do_op("rol3", 3'd4, 3, 8'h00, 2, 2, 1'b0);
    chk("rol3_const", 64'(bus.data_out), 64'h27);
    do_op("load80", 3'd1, 0, 8'h80, 0, 0, 1'b0);
    do_op("asr2", 3'd6, 2, 8'h00, 2, 2, 1'b0);
    chk("asr2_const", 64'(bus.data_out), 64'hE0);
    do_op("loadFF", 3'd1, 0, 8'hFF, 0, 0, 1'b0);
    do_op("shl9sat", 3'd2, 9, 8'h00, 0, 2, 1'b0);
    chk("shl9sat_const", 64'(bus.data_out), 64'h00);
    do_op("load5A", 3'd1, 0, 8'h5A, 0, 0, 1'b0);
    do_op("op7", 3'd7, 5, 8'hFF, 2, 2, 1'b0);
    do_op("op0", 3'd0, 5, 8'hFF, 2, 2, 1'b0);
    do_op("amt0", 3'd5, 0, 8'hFF, 2, 2, 1'b0);
    chk("noop_const", 64'(bus.data_out), 64'h5A);
    do_op("ror15sat", 3'd5, 15, 8'h00, 2, 2, 1'b0);
    chk("ror15sat_const", 64'(bus.data_out), 64'h5A);
    do_op("poke", 3'd4, 3, 8'h00, 2, 2, 1'b1);
    chk("poke_const", 64'(bus.data_out), 64'hD2);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      do_op("rnd", 3'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            8'($urandom), 2, 2, 1'($urandom));
    end

    // Reset midway through an 8-step shift
    do_op("preA5", 3'd1, 0, 8'hA5, 0, 0, 1'b0);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = 3'd2;
    bus.amount = AW'(8);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) begin
      bus.i_right = 1'($urandom);
      @(negedge clk);
    end
    chk("mid_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_data", 64'(bus.data_out), 64'd0);
    chk("async_busy", 64'(bus.busy), 64'd0);
    chk("async_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cur   = 8'h00;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_done", 64'(bus.done), 64'd0);
      chk("post_rst_busy", 64'(bus.busy), 64'd0);
    end
    chk("post_rst_data", 64'(bus.data_out), 64'd0);
    do_op("post_rst_load", 3'd1, 0, 8'h96, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_reg_seq.md
SHIFT_REG_SEQ -- requirements
Module: shift_reg_seq

Interface
REQ-001 The block SHALL have parameter N, default 8, register width in bits, legal range 2..64.
REQ-002 The block SHALL have parameter AW, default $clog2(N)+1, width of the shift-amount port.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, operation request, sampled only in IDLE.
REQ-006 The block SHALL have port op, input, 3, operation code, sampled with start.
REQ-007 The block SHALL have port amount, input, AW, number of single-bit steps, sampled with start.
REQ-008 The block SHALL have port data_in, input, N, parallel load value.
REQ-009 The block SHALL have port i_right, input, 1, serial fill bit entering the LSB on shift-left.
REQ-010 The block SHALL have port i_left, input, 1, serial fill bit entering the MSB on shift-right.
REQ-011 The block SHALL have port data_out, output, N, register contents.
REQ-012 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-013 The block SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-014 The op encoding SHALL be: 0 no-op, 1 load, 2 shift left, 3 shift right (logical, i_left fill), 4 rotate left, 5 rotate right, 6 arithmetic right (MSB replicated), 7 reserved (treated as no-op).
REQ-015 The FSM SHALL have three states, IDLE, RUN and DONE, and SHALL never occupy any other state.
REQ-016 In IDLE, if start=0, the FSM SHALL hold all state, and data_out SHALL be unchanged.
REQ-017 In IDLE, with start=1 and op=1, the edge SHALL set data_out to data_in, and the FSM SHALL go to DONE.
REQ-018 In IDLE, with start=1 and op in {0,7}, or a shift/rotate op with amount=0, the FSM SHALL go to DONE with data_out unchanged.
REQ-019 In IDLE, with start=1 and a shift/rotate op with amount>=1, the block SHALL latch op, set remaining = min(amount, N), and go to RUN with no shift on that edge.
REQ-020 In RUN, each edge SHALL perform exactly one single-bit step of the latched op and decrement remaining; the step that brings remaining to 0 SHALL also move the FSM to DONE.
REQ-021 Serial inputs i_right and i_left SHALL be sampled on every RUN step edge, not latched at start.
REQ-022 In DONE, done SHALL be 1 for exactly that one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-023 Latency from the start edge to the done cycle SHALL be 1 cycle for load, no-op and zero-amount requests, and remaining+1 cycles for shifts.
REQ-024 start SHALL be ignored in RUN and DONE, and op and amount SHALL have no effect outside the start edge.
REQ-025 An amount greater than N SHALL saturate to N, so a rotate by N returns the original value.
REQ-026 done and busy SHALL be registered outputs, i.e. decoded from state flops with no combinational path from any input.

Reset
REQ-027 While rst_n=0, the block SHALL force data_out=0, busy=0, done=0, state=IDLE and remaining=0, independent of clk.
REQ-028 Assertion of rst_n mid-RUN SHALL abandon the operation immediately, and no done pulse SHALL follow.
REQ-029 After rst_n deasserts, the first edge SHALL be a normal IDLE edge.

Verification (N=8)
REQ-030 Load: start, op=1, data_in=0x64 -> data_out=0x64, done high the cycle after the start edge, busy high for that one cycle.
REQ-031 Shift left: from 0x64, op=2, amount=1, i_right=1 -> data_out=0xC9, done 2 cycles after the start edge; then op=3, amount=1, i_left=1 -> 0xE4.
REQ-032 Rotate and arithmetic shift: from 0xE4, op=4, amount=3 -> 0x27; from 0x80, op=6, amount=2 -> 0xE0; done 4 and 3 cycles after start respectively.
REQ-033 Saturation and no-op: from 0xFF, op=2, amount=9, i_right=0 -> 0x00 after exactly 8 steps, done 9 cycles after start; op=7 or amount=0 -> data_out unchanged, done after 1 cycle.
REQ-034 Protocol: start pulsed during RUN with a different op -> ignored, the result matches the original op only.
REQ-035 Reset: rst_n low midway through an 8-step shift -> data_out=0, busy=0 asynchronously, with no subsequent done pulse.
